// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer: initiator-side controller for the 64-point FFT stage
// counter. Launches the counter once per butterfly stage, advances the one-hot
// span on each new_stage response, and reports completion, watchdog timeout and
// protocol (unexpected new_stage) errors to the FFT top-level control.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   go           one-cycle transform request, honoured only when idle
//   abort        cancel the current transform, honoured when not idle
//   new_stage    end-of-stage pulse from the counter
//   count        counter output value, observation only
//   start        one-cycle launch pulse to the counter
//   stage        one-hot butterfly span to the counter
//   stage_idx    index of the current stage
//   busy         high while launching or running a stage
//   done         one-cycle pulse after the last stage completes
//   err_timeout  sticky watchdog error, cleared by the next accepted go
//   err_seq      sticky protocol error, cleared by the next accepted go
module fft_stage_sequencer #(
  parameter int unsigned NUM_STAGES = 6,
  parameter int unsigned STAGE_W    = 6,
  parameter int unsigned TIMEOUT    = 128
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               go,
  input  logic               abort,
  input  logic               new_stage,
  input  logic [5:0]         count,
  output logic               start,
  output logic [STAGE_W-1:0] stage,
  output logic [2:0]         stage_idx,
  output logic               busy,
  output logic               done,
  output logic               err_timeout,
  output logic               err_seq
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

  localparam logic [TMR_W-1:0]   TMR_LAST    = TMR_W'(TIMEOUT - 1);
  localparam logic [2:0]         IDX_LAST    = 3'(NUM_STAGES - 1);
  localparam logic [STAGE_W-1:0] STAGE_FIRST = STAGE_W'(1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LAUNCH = 2'd1;
  localparam logic [1:0] RUN    = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]         state;
  logic [1:0]         state_nxt;
  logic [TMR_W-1:0]   timer;
  logic [TMR_W-1:0]   timer_nxt;
  logic [STAGE_W-1:0] stage_nxt;
  logic [2:0]         idx_nxt;
  logic               err_timeout_nxt;
  logic               err_seq_nxt;

  // count is a debug observation point only; fold it so it is not flagged unused
  logic unused_count;
  assign unused_count = ^count;

  // State, watchdog and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      timer       <= '0;
      start       <= 1'b0;
      stage       <= '0;
      stage_idx   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
      err_seq     <= 1'b0;
    end else begin
      state       <= state_nxt;
      timer       <= timer_nxt;
      start       <= (state_nxt == LAUNCH);
      stage       <= stage_nxt;
      stage_idx   <= idx_nxt;
      busy        <= (state_nxt == LAUNCH) || (state_nxt == RUN);
      done        <= (state_nxt == DONE);
      err_timeout <= err_timeout_nxt;
      err_seq     <= err_seq_nxt;
    end
  end

  // Next-state, span, watchdog and error-flag logic
  always_comb begin
    state_nxt       = state;
    timer_nxt       = '0;
    stage_nxt       = stage;
    idx_nxt         = stage_idx;
    err_timeout_nxt = err_timeout;
    err_seq_nxt     = err_seq;

    case (state)
      IDLE: begin
        if (go) begin
          state_nxt       = LAUNCH;
          stage_nxt       = STAGE_FIRST;
          idx_nxt         = '0;
          err_timeout_nxt = 1'b0;
          err_seq_nxt     = 1'b0;
        end
      end

      LAUNCH: begin
        state_nxt = RUN;
      end

      RUN: begin
        timer_nxt = timer + TMR_W'(1);
        // new_stage takes priority over a watchdog expiry in the same cycle
        if (new_stage) begin
          timer_nxt = '0;
          if (stage_idx == IDX_LAST) begin
            state_nxt = DONE;
          end else begin
            state_nxt = LAUNCH;
            stage_nxt = {stage[STAGE_W-2:0], 1'b0};
            idx_nxt   = stage_idx + 3'd1;
          end
        end else if (timer == TMR_LAST) begin
          state_nxt       = IDLE;
          stage_nxt       = '0;
          idx_nxt         = '0;
          err_timeout_nxt = 1'b1;
        end
      end

      DONE: begin
        state_nxt = IDLE;
        stage_nxt = '0;
        idx_nxt   = '0;
      end

      default: begin
        state_nxt = IDLE;
        stage_nxt = '0;
        idx_nxt   = '0;
      end
    endcase

    // Abort overrides every in-flight transition, including a watchdog expiry
    if (abort && (state != IDLE)) begin
      state_nxt       = IDLE;
      stage_nxt       = '0;
      idx_nxt         = '0;
      timer_nxt       = '0;
      err_timeout_nxt = err_timeout;
    end

    // new_stage is only legal while a stage is running
    if (new_stage && (state != RUN)) begin
      err_seq_nxt = 1'b1;
    end
  end

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb_fft_stage_sequencer: scoreboard bench for fft_stage_sequencer. Directed
// stimulus pushes expected start/done pulses and output snapshots into queues;
// a negedge monitor pops and compares them as the DUT presents outputs.
module tb_fft_stage_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       go;
  logic       abort;
  logic       new_stage;
  logic       ns_force;
  logic       ns_model;
  logic [5:0] count;
  logic       start;
  logic [5:0] stage;
  logic [2:0] stage_idx;
  logic       busy;
  logic       done;
  logic       err_timeout;
  logic       err_seq;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  bit model_en = 1'b0;
  int ns_due = -1;

  typedef struct {
    int         cyc;
    bit         is_done;
    logic [5:0] stage;
    logic [2:0] idx;
  } ev_t;

  typedef struct {
    int          cyc;
    logic [13:0] v;
  } snap_t;

  ev_t   evq[$];
  snap_t snq[$];
  ev_t   e;
  snap_t s;
  logic [13:0] act;

  fft_stage_sequencer #(
    .NUM_STAGES(6),
    .STAGE_W(6),
    .TIMEOUT(128)
  ) dut (
    .clk(clk),
    .rst(rst),
    .go(go),
    .abort(abort),
    .new_stage(new_stage),
    .count(count),
    .start(start),
    .stage(stage),
    .stage_idx(stage_idx),
    .busy(busy),
    .done(done),
    .err_timeout(err_timeout),
    .err_seq(err_seq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign new_stage = ns_force | ns_model;
  assign count = 6'(cyc);

  // Counter model: answers each start with new_stage 64 cycles later
  always @(negedge clk) begin
    if (!busy) ns_due = -1;
    if (start) ns_due = cyc + 64;
    ns_model = model_en && (cyc == ns_due);
  end

  function automatic logic [13:0] mk(input logic st, input logic [5:0] sg, input logic [2:0] ix,
                                     input logic bz, input logic dn, input logic et, input logic es);
    return {st, sg, ix, bz, dn, et, es};
  endfunction

  function automatic void push_ev(input int c, input bit d, input logic [5:0] sg, input logic [2:0] ix);
    ev_t x;
    x.cyc = c; x.is_done = d; x.stage = sg; x.idx = ix;
    evq.push_back(x);
  endfunction

  function automatic void push_snap(input int c, input logic [13:0] v);
    snap_t x;
    x.cyc = c; x.v = v;
    snq.push_back(x);
  endfunction

  // Monitor: pulse scoreboard plus cycle-tagged output snapshots
  always @(negedge clk) begin
    while (evq.size() > 0 && evq[0].cyc < cyc) begin
      e = evq.pop_front();
      checks++; errors++;
      $display("FAIL pulse_missing: no %s seen at cycle %0d", e.is_done ? "done" : "start", e.cyc);
    end
    if (start === 1'b1 || done === 1'b1) begin
      checks++;
      if (evq.size() == 0 || evq[0].cyc != cyc) begin
        errors++;
        $display("FAIL pulse_unexpected: start=%0b done=%0b at cycle %0d, required no pulse", start, done, cyc);
      end else begin
        e = evq.pop_front();
        if (e.is_done != done || e.stage != stage || e.idx != stage_idx) begin
          errors++;
          $display("FAIL pulse_fields cycle %0d: done=%0b stage=%b idx=%0d, required done=%0b stage=%b idx=%0d",
                   cyc, done, stage, stage_idx, e.is_done, e.stage, e.idx);
        end
      end
    end
    if (snq.size() > 0 && snq[0].cyc == cyc) begin
      s = snq.pop_front();
      act = mk(start, stage, stage_idx, busy, done, err_timeout, err_seq);
      checks++;
      if (act !== s.v) begin
        errors++;
        $display("FAIL snapshot cycle %0d {start,stage,idx,busy,done,et,es}: got %b, required %b", cyc, act, s.v);
      end
    end
  end

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_go(input int c);
    goto(c); go = 1'b1; goto(c + 1); go = 1'b0;
  endtask

  task automatic pulse_abort(input int c);
    goto(c); abort = 1'b1; goto(c + 1); abort = 1'b0;
  endtask

  task automatic pulse_ns(input int c);
    goto(c); ns_force = 1'b1; goto(c + 1); ns_force = 1'b0;
  endtask

  task automatic pulse_rst(input int c);
    goto(c); rst = 1'b1; goto(c + 1); rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; go = 1'b0; abort = 1'b0; ns_force = 1'b0; ns_model = 1'b0;
    push_snap(2, 14'h0);
    goto(2);
    rst = 1'b0;

    // Nominal run, go at 10; redundant go pulses mid-run and in the DONE cycle
    model_en = 1'b1;
    for (int k = 0; k < 6; k++) push_ev(11 + 65 * k, 1'b0, 6'(1 << k), 3'(k));
    push_ev(401, 1'b1, 6'b100000, 3'd5);
    push_snap(11,  mk(1, 6'b000001, 3'd0, 1, 0, 0, 0));
    push_snap(21,  mk(0, 6'b000001, 3'd0, 1, 0, 0, 0));
    push_snap(22,  mk(0, 6'b000001, 3'd0, 1, 0, 0, 0));
    push_snap(400, mk(0, 6'b100000, 3'd5, 1, 0, 0, 0));
    push_snap(401, mk(0, 6'b100000, 3'd5, 0, 1, 0, 0));
    push_snap(402, 14'h0);
    push_snap(403, 14'h0);
    pulse_go(10);
    pulse_go(20);
    pulse_go(21);
    pulse_go(401);
    goto(410);

    // Watchdog timeout with a silent counter, then go clears the flag
    model_en = 1'b0;
    push_ev(421, 1'b0, 6'b000001, 3'd0);
    push_snap(549, mk(0, 6'b000001, 3'd0, 1, 0, 0, 0));
    push_snap(550, mk(0, 6'b000000, 3'd0, 0, 0, 1, 0));
    push_snap(559, mk(0, 6'b000000, 3'd0, 0, 0, 1, 0));
    push_ev(561, 1'b0, 6'b000001, 3'd0);
    push_snap(561, mk(1, 6'b000001, 3'd0, 1, 0, 0, 0));
    push_snap(566, 14'h0);
    pulse_go(420);
    pulse_go(560);
    pulse_abort(565);
    goto(590);

    // Abort mid-run during stage 2
    model_en = 1'b1;
    push_ev(601, 1'b0, 6'b000001, 3'd0);
    push_ev(666, 1'b0, 6'b000010, 3'd1);
    push_ev(731, 1'b0, 6'b000100, 3'd2);
    push_snap(750, mk(0, 6'b000100, 3'd2, 1, 0, 0, 0));
    push_snap(751, 14'h0);
    pulse_go(600);
    pulse_abort(750);
    goto(790);

    // Abort and new_stage in the same cycle: abort wins
    push_ev(801, 1'b0, 6'b000001, 3'd0);
    push_snap(865, mk(0, 6'b000001, 3'd0, 1, 0, 0, 0));
    push_snap(866, 14'h0);
    pulse_go(800);
    pulse_abort(865);
    goto(890);

    // Protocol errors: new_stage while idle and during LAUNCH; sticky across abort
    model_en = 1'b0;
    push_snap(901, mk(0, 6'b000000, 3'd0, 0, 0, 0, 1));
    push_ev(911, 1'b0, 6'b000001, 3'd0);
    push_snap(911, mk(1, 6'b000001, 3'd0, 1, 0, 0, 0));
    push_snap(912, mk(0, 6'b000001, 3'd0, 1, 0, 0, 1));
    push_snap(916, mk(0, 6'b000000, 3'd0, 0, 0, 0, 1));
    pulse_ns(900);
    pulse_go(910);
    pulse_ns(911);
    pulse_abort(915);
    goto(990);

    // Reset mid-run clears everything including sticky flags
    model_en = 1'b1;
    push_ev(1001, 1'b0, 6'b000001, 3'd0);
    push_snap(1002, mk(0, 6'b000001, 3'd0, 1, 0, 0, 1));
    push_ev(1066, 1'b0, 6'b000010, 3'd1);
    push_ev(1131, 1'b0, 6'b000100, 3'd2);
    push_ev(1196, 1'b0, 6'b001000, 3'd3);
    push_snap(1200, mk(0, 6'b001000, 3'd3, 1, 0, 0, 1));
    push_snap(1201, 14'h0);
    push_ev(1206, 1'b0, 6'b000001, 3'd0);
    push_snap(1206, mk(1, 6'b000001, 3'd0, 1, 0, 0, 0));
    push_snap(1211, 14'h0);
    pulse_go(1000);
    pulse_ns(1001);
    pulse_rst(1200);
    pulse_go(1205);
    pulse_abort(1210);
    goto(1300);

    while (evq.size() > 0) begin
      e = evq.pop_front();
      checks++; errors++;
      $display("FAIL pulse_missing_end: no %s seen at cycle %0d", e.is_done ? "done" : "start", e.cyc);
    end
    while (snq.size() > 0) begin
      s = snq.pop_front();
      checks++; errors++;
      $display("FAIL snapshot_missing_end: cycle %0d never sampled, required %b", s.cyc, s.v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_stage_sequencer.md
Name: fft_stage_sequencer

Overview:
- Initiator-side controller for the 64-point FFT stage counter (CountTo64).
- Drives the counter's start/stage inputs, consumes its new_stage/out responses, and steps through all NUM_STAGES butterfly stages for one transform.
- Reports completion, timeout and protocol errors to the top-level FFT control.
- Sits between the FFT top-level control and the counter instance.

Parameters:
NUM_STAGES, 6, number of butterfly stages per transform (log2 of 64).
STAGE_W, 6, width of the one-hot stage span bus; equals NUM_STAGES.
TIMEOUT, 128, max cycles in RUN without new_stage before abort; must be > 64.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous active-high reset.
go  input  1  one-cycle transform request; honoured only in IDLE.
abort  input  1  cancel current transform; honoured in any non-IDLE state.
new_stage  input  1  end-of-stage pulse from counter.
count  input  6  counter out value; monitored only.
start  output  1  one-cycle launch pulse to counter.
stage  output  STAGE_W  one-hot butterfly span to counter.
stage_idx  output  3  index of current stage, 0..NUM_STAGES-1.
busy  output  1  high in LAUNCH and RUN.
done  output  1  one-cycle pulse when the last stage completes.
err_timeout  output  1  sticky; cleared by the next accepted go.
err_seq  output  1  sticky; set by an unexpected new_stage; cleared by the next accepted go.

Behaviour:
- Interface: single clock clk; reset rst is synchronous and active-high.
- Reset values: state IDLE; start=0, stage=0, stage_idx=0, busy=0, done=0, err_timeout=0, err_seq=0; watchdog timer=0.
- States: IDLE, LAUNCH, RUN, DONE.
- IDLE, go=1 (accepted): next cycle enters LAUNCH.
  - stage=6'b000001, stage_idx=0.
  - err_timeout and err_seq cleared.
- LAUNCH: lasts one cycle; start=1, busy=1; next state RUN; watchdog timer cleared to 0.
- RUN: start=0, busy=1; timer increments each cycle.
  - new_stage=1 and stage_idx<NUM_STAGES-1: next cycle LAUNCH, stage shifted left by 1, stage_idx+1, timer cleared.
  - new_stage=1 and stage_idx==NUM_STAGES-1: next cycle DONE.
  - new_stage=0 and timer==TIMEOUT-1: next cycle IDLE, err_timeout=1, stage=0, busy=0.
- DONE: lasts one cycle; done=1, busy=0, stage held; next state IDLE, where stage and stage_idx return to 0.
- go while not in IDLE (including the DONE cycle): ignored; no queuing.
- abort in LAUNCH, RUN or DONE: next cycle IDLE, outputs return to reset values except sticky error flags; no done pulse. abort in IDLE has no effect.
- Simultaneous abort and new_stage: abort wins.
- Simultaneous new_stage and timer reaching TIMEOUT-1: new_stage wins; no timeout.
- new_stage in IDLE, LAUNCH or DONE: err_seq=1; state unaffected.
- Latency:
  - go to first start: 1 cycle.
  - new_stage to next start: 1 cycle.
  - last new_stage to done: 1 cycle.
- count is not used for control; it is a debug/verification observation point only.
- rst asserted mid-transform: next cycle all outputs at reset values, including the error flags.

Test Plan:
1. Nominal run. Counter model pulses new_stage 64 cycles after each start; go at cycle 0.
   -> start at cycles 1, 66, 131, 196, 261, 326.
   -> stage takes values 000001, 000010, 000100, 001000, 010000, 100000 in turn.
   -> done=1 only at cycle 391; busy=0 from 391.
   -> err flags stay 0.
2. Timeout. go at cycle 0; model never responds.
   -> start at cycle 1; err_timeout=1 and state IDLE at cycle 130; busy=0; no done.
   -> A following go at cycle 140 clears err_timeout at cycle 141.
3. Abort mid-run. Nominal run with abort=1 at cycle 150 (stage_idx=2).
   -> cycle 151: busy=0, stage=0, stage_idx=0, no further start pulses, done never asserts.
4. Abort/new_stage collision. abort and new_stage both at cycle 65.
   -> IDLE at cycle 66, no start at 66, stage=0.
5. Protocol errors.
   -> new_stage pulse while IDLE: err_seq=1 next cycle, busy stays 0.
   -> go pulses at cycles 10 and 11 of an active run: ignored, schedule unchanged.
6. Reset mid-run. rst=1 at cycle 200 for one cycle.
   -> cycle 201: all outputs at reset values.
   -> A new go at cycle 205 gives start at 206.
